// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB-first,
// WIDTH+1 clock edges from accepted start to the done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q, res_sr_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;

  logic accept, last_bit, s_bit, c_next;

  // Handshake: a start is taken on any edge where the unit is not in RUN;
  // requests during RUN are dropped, and done is the single DONE cycle.
  assign accept   = start && (state_q != RUN);
  assign last_bit = (cnt_q == LAST);
  assign s_bit    = opa_q[0] ^ opb_q[0] ^ c_q;
  assign c_next   = (opa_q[0] & opb_q[0]) | (opa_q[0] & c_q) | (opb_q[0] & c_q);

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q     <= '0;
      opb_q     <= '0;
      res_sr_q  <= '0;
      cnt_q     <= '0;
      c_q       <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
      opa_q <= a;
      opb_q <= sub ? ~b : b;
      c_q   <= sub;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      opa_q    <= opa_q >> 1;
      opb_q    <= opb_q >> 1;
      c_q      <= c_next;
      cnt_q    <= cnt_q + ONE;
      res_sr_q <= {s_bit, res_sr_q[WIDTH-1:1]};
      if (last_bit) begin
        // c_q still holds the carry into the MSB at this point.
        sum       <= {s_bit, res_sr_q[WIDTH-1:1]};
        carry_out <= c_next;
        overflow  <= c_next ^ c_q;
      end
    end
  end

endmodule
